sha3_msg_sequencer: RTL and testbench

SHA3_MSG_SEQUENCER -- requirements
Module: sha3_msg_sequencer

---
 rtl/sha3_msg_sequencer_pkg.sv | 17 +
 rtl/sha3_pad_block.sv | 53 +++++
 rtl/sha3_msg_sequencer.sv | 133 +++++++++++++
 tb/tb_sha3_msg_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_msg_sequencer_pkg.sv
// Shared types and constants for the SHA-3 message sequencer: FSM encoding,
// the final pad bit and the default sponge geometry.
package sha3_msg_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABSORB  = 2'd1,
        ST_SQUEEZE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] FINAL_PAD        = 8'h80;
    localparam int         DEFAULT_RATE     = 1088;
    localparam int         DEFAULT_DIGEST_W = 512;
    localparam logic [7:0] DEFAULT_DS_BYTE  = 8'h1F;

endpackage

// File: rtl/sha3_pad_block.sv
// Combinational SHA-3 pad10*1 block builder: selects one rate block of the
// message and overlays the domain-separation byte and the final pad bit.
module sha3_pad_block
    import sha3_msg_sequencer_pkg::*;
#(
    parameter int         RATE       = DEFAULT_RATE,
    parameter int         MAX_BLOCKS = 20,
    parameter logic [7:0] DS_BYTE    = DEFAULT_DS_BYTE,
    parameter int         LEN_W      = 16,
    parameter int         IDX_W      = 5
) (
    input  logic [IDX_W-1:0]           blk_idx,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic [MAX_BLOCKS*RATE-1:0] msg,
    output logic [RATE-1:0]            blk_data
);

    localparam int RB     = RATE / 8;
    localparam int MSG_W  = MAX_BLOCKS * RATE;
    localparam int MSG_AW = $clog2(MSG_W);

    logic [31:0]       base_pos;
    logic [31:0]       len_pos;
    logic              final_blk;
    logic [IDX_W-1:0]  idx_c;
    logic [MSG_AW-1:0] raw_top;
    logic [RATE-1:0]   raw;

    assign base_pos  = 32'(blk_idx) * 32'(RB);
    assign len_pos   = 32'(msg_len);
    assign final_blk = (32'(blk_idx) == (len_pos / 32'(RB)));

    // The counter may step one past the last block; clamp so the select stays in range.
    assign idx_c   = (32'(blk_idx) < 32'(MAX_BLOCKS)) ? blk_idx : '0;
    assign raw_top = MSG_AW'(32'(MSG_W - 1) - 32'(idx_c) * 32'(RATE));
    assign raw     = msg[raw_top -: RATE];

    for (genvar gi = 0; gi < RB; gi++) begin : g_byte
        logic [31:0] pos;
        logic [7:0]  body;

        assign pos  = base_pos + 32'(gi);
        assign body = (pos < len_pos)  ? raw[RATE-1-8*gi -: 8] :
                      (pos == len_pos) ? DS_BYTE : 8'h00;

        if (gi == RB - 1) begin : g_tail
            assign blk_data[RATE-1-8*gi -: 8] = body | (final_blk ? FINAL_PAD : 8'h00);
        end else begin : g_body
            assign blk_data[RATE-1-8*gi -: 8] = body;
        end
    end

endmodule

// File: rtl/sha3_msg_sequencer.sv
// Feeds a padded multi-block message to a SHA-3 sponge core, requests the
// squeeze and captures the resulting digest.
module sha3_msg_sequencer
    import sha3_msg_sequencer_pkg::*;
#(
    parameter int         RATE       = DEFAULT_RATE,
    parameter int         MAX_BLOCKS = 20,
    parameter int         DIGEST_W   = DEFAULT_DIGEST_W,
    parameter logic [7:0] DS_BYTE    = DEFAULT_DS_BYTE,
    parameter int         LEN_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic [MAX_BLOCKS*RATE-1:0] msg,
    output logic [RATE-1:0]            blk_data,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic                       blk_last,
    output logic                       sq_req,
    input  logic                       sq_ack,
    input  logic [DIGEST_W-1:0]        core_digest,
    output logic [DIGEST_W-1:0]        digest,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int RB        = RATE / 8;
    localparam int MAX_BYTES = MAX_BLOCKS * RB;
    localparam int CNT_W     = $clog2(MAX_BLOCKS + 1);

    state_t            state;
    logic [CNT_W-1:0]  blk_cnt;
    logic [CNT_W-1:0]  last_idx;
    logic [LEN_W-1:0]  len_reg;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  accept_last;
    logic              overflow;

    assign cnt_inc     = blk_cnt + CNT_W'(1);
    assign overflow    = (32'(msg_len) >= 32'(MAX_BYTES));
    assign accept_last = CNT_W'(32'(msg_len) / 32'(RB));

    sha3_pad_block #(
        .RATE       (RATE),
        .MAX_BLOCKS (MAX_BLOCKS),
        .DS_BYTE    (DS_BYTE),
        .LEN_W      (LEN_W),
        .IDX_W      (CNT_W)
    ) u_pad (
        .blk_idx  (blk_cnt),
        .msg_len  (len_reg),
        .msg      (msg),
        .blk_data (blk_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            blk_cnt   <= '0;
            last_idx  <= '0;
            len_reg   <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            sq_req    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            digest    <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            sq_req    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err <= overflow;
                        if (overflow) begin
                            // Oversized job: skip straight to the completion pulse.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_ABSORB;
                            len_reg   <= msg_len;
                            last_idx  <= accept_last;
                            blk_cnt   <= '0;
                            blk_valid <= 1'b1;
                            blk_last  <= (accept_last == '0);
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_ABSORB: begin
                    if (blk_ready) begin
                        blk_cnt <= cnt_inc;
                        if (blk_cnt == last_idx) begin
                            state     <= ST_SQUEEZE;
                            blk_valid <= 1'b0;
                            blk_last  <= 1'b0;
                            sq_req    <= 1'b1;
                        end else begin
                            blk_last <= (cnt_inc == last_idx);
                        end
                    end
                end
                ST_SQUEEZE: begin
                    if (sq_ack) begin
                        digest <= core_digest;
                        sq_req <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// Directed bench for sha3_msg_sequencer: expected padded blocks are queued at
// job start and popped on every block handshake.
module tb_sha3_msg_sequencer;

    localparam int         RATE       = 1088;
    localparam int         MAX_BLOCKS = 20;
    localparam int         DIGEST_W   = 512;
    localparam logic [7:0] DS_BYTE    = 8'h1F;
    localparam int         LEN_W      = 16;
    localparam int         RB         = RATE / 8;
    localparam int         MSG_W      = MAX_BLOCKS * RATE;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [LEN_W-1:0]    msg_len;
    logic [MSG_W-1:0]    msg;
    logic [RATE-1:0]     blk_data;
    logic                blk_valid;
    logic                blk_ready;
    logic                blk_last;
    logic                sq_req;
    logic                sq_ack;
    logic [DIGEST_W-1:0] core_digest;
    logic [DIGEST_W-1:0] digest;
    logic                busy;
    logic                done;
    logic                err;

    always #5 clk = ~clk;

    sha3_msg_sequencer #(
        .RATE       (RATE),
        .MAX_BLOCKS (MAX_BLOCKS),
        .DIGEST_W   (DIGEST_W),
        .DS_BYTE    (DS_BYTE),
        .LEN_W      (LEN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .msg_len     (msg_len),
        .msg         (msg),
        .blk_data    (blk_data),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_last    (blk_last),
        .sq_req      (sq_req),
        .sq_ack      (sq_ack),
        .core_digest (core_digest),
        .digest      (digest),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [RATE-1:0] data;
        logic            last;
    } blk_t;

    blk_t                sb[$];
    int                  vectors     = 0;
    int                  miscompares = 0;
    int                  hs_count    = 0;
    bit                  stall_pending = 1'b0;
    logic [RATE-1:0]     stall_data;
    logic                stall_last;
    logic [DIGEST_W-1:0] exp_digest = '0;

    // Reference pad10*1 built byte by byte, byte 0 shifted in first so it lands in the MSBs.
    function automatic logic [RATE-1:0] model_block(input int len, input int k);
        logic [RATE-1:0]  b;
        logic [MSG_W-1:0] src;
        logic [7:0]       by;
        int               p;
        b   = '0;
        src = msg << (k * RATE);
        for (int j = 0; j < RB; j++) begin
            p = k * RB + j;
            if (p < len)       by = src[MSG_W-1 -: 8];
            else if (p == len) by = DS_BYTE;
            else               by = 8'h00;
            if (j == RB - 1 && k == len / RB) by = by | 8'h80;
            b   = {b[RATE-9:0], by};
            src = src << 8;
        end
        return b;
    endfunction

    function automatic int first_diff(input logic [RATE-1:0] a, input logic [RATE-1:0] b);
        logic [RATE-1:0] x;
        x = a ^ b;
        for (int j = 0; j < RB; j++) begin
            if (x[RATE-1 -: 8] != 8'h00) return j;
            x = x << 8;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [DIGEST_W-1:0] obs, input logic [DIGEST_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_block(input string tag, input logic [RATE-1:0] obs, input logic [RATE-1:0] exp);
        int d;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            d = first_diff(obs, exp);
            $error("FAIL %s: first differing byte %0d observed block=%0h expected block=%0h (low 64 bits)",
                   tag, d, obs[63:0], exp[63:0]);
        end
    endtask

    // Check handshakes/stalls that the next edge will act on, then advance one cycle.
    task automatic step();
        blk_t e;
        bit   live;
        live = reset && !abort;
        if (stall_pending) begin
            chk_block("stall_data_stable", blk_data, stall_data);
            chk("stall_last_stable", DIGEST_W'(blk_last), DIGEST_W'(stall_last));
        end
        stall_pending = live && blk_valid && !blk_ready;
        stall_data    = blk_data;
        stall_last    = blk_last;
        if (live && blk_valid && blk_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                chk("unexpected_block", DIGEST_W'(1), DIGEST_W'(0));
            end else begin
                e = sb.pop_front();
                chk_block("blk_data", blk_data, e.data);
                chk("blk_last", DIGEST_W'(blk_last), DIGEST_W'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_blocks(input int len);
        int   n;
        blk_t e;
        n = len / RB + 1;
        for (int k = 0; k < n; k++) begin
            e.data = model_block(len, k);
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic run_job(input int len, input bit toggle);
        int                  n;
        int                  edges;
        bit                  ovf;
        bit                  seen_valid;
        bit                  got_done;
        logic [DIGEST_W-1:0] dig;
        n   = len / RB + 1;
        ovf = (len >= MAX_BLOCKS * RB);
        if (!ovf) push_blocks(len);
        for (int i = 0; i < DIGEST_W / 32; i++) dig = {dig[DIGEST_W-33:0], 32'($urandom)};
        core_digest = dig;
        sq_ack      = 1'b1;
        blk_ready   = 1'b1;
        hs_count    = 0;
        msg_len     = LEN_W'(len);
        start       = 1'b1;
        step();
        start      = 1'b0;
        edges      = 1;
        seen_valid = blk_valid;
        got_done   = done;
        while (!got_done && edges < 400) begin
            blk_ready = toggle ? (edges % 2 == 1) : 1'b1;
            step();
            edges++;
            seen_valid = seen_valid | blk_valid;
            got_done   = done;
        end
        blk_ready = 1'b1;
        chk($sformatf("done_seen len=%0d", len), DIGEST_W'(got_done), DIGEST_W'(1));
        chk("busy_at_done", DIGEST_W'(busy), DIGEST_W'(0));
        chk("err_at_done", DIGEST_W'(err), DIGEST_W'(ovf));
        chk("queue_drained", DIGEST_W'(sb.size()), DIGEST_W'(0));
        if (ovf) begin
            chk("no_block_on_overflow", DIGEST_W'(seen_valid), DIGEST_W'(0));
            chk("no_handshake_on_overflow", DIGEST_W'(hs_count), DIGEST_W'(0));
        end else begin
            exp_digest = dig;
            chk("block_count", DIGEST_W'(hs_count), DIGEST_W'(n));
            if (!toggle) chk("latency_cycles", DIGEST_W'(edges + 1), DIGEST_W'(n + 3));
        end
        chk("digest", digest, exp_digest);
        sb.delete();
        step();
        chk("done_one_cycle", DIGEST_W'(done), DIGEST_W'(0));
        $display("job len=%0d blocks=%0d edges=%0d err=%0b", len, hs_count, edges, err);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        msg_len     = '0;
        blk_ready   = 1'b0;
        sq_ack      = 1'b0;
        core_digest = '0;
        msg         = '0;
        for (int i = 0; i < MSG_W / 32; i++) msg = {msg[MSG_W-33:0], 32'($urandom)};

        step();
        step();
        chk("rst_blk_valid", DIGEST_W'(blk_valid), DIGEST_W'(0));
        chk("rst_blk_last", DIGEST_W'(blk_last), DIGEST_W'(0));
        chk("rst_sq_req", DIGEST_W'(sq_req), DIGEST_W'(0));
        chk("rst_busy", DIGEST_W'(busy), DIGEST_W'(0));
        chk("rst_done", DIGEST_W'(done), DIGEST_W'(0));
        chk("rst_err", DIGEST_W'(err), DIGEST_W'(0));
        chk("rst_digest", digest, '0);
        reset = 1'b1;
        step();

        run_job(0, 1'b0);
        run_job(135, 1'b0);
        run_job(136, 1'b0);
        run_job(300, 1'b1);
        run_job(2720, 1'b0);
        chk("err_held_in_idle", DIGEST_W'(err), DIGEST_W'(1));
        run_job(50, 1'b0);

        // Abort while the squeeze request is pending.
        push_blocks(10);
        core_digest = ~exp_digest;
        sq_ack      = 1'b0;
        blk_ready   = 1'b1;
        msg_len     = LEN_W'(10);
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !sq_req; i++) step();
        chk("abort_sq_req_reached", DIGEST_W'(sq_req), DIGEST_W'(1));
        abort = 1'b1;
        step();
        abort  = 1'b0;
        sq_ack = 1'b1;
        chk("abort_sq_req_low", DIGEST_W'(sq_req), DIGEST_W'(0));
        chk("abort_busy_low", DIGEST_W'(busy), DIGEST_W'(0));
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", DIGEST_W'(done), DIGEST_W'(0));
            step();
        end
        chk("abort_digest_kept", digest, exp_digest);
        chk("abort_queue_drained", DIGEST_W'(sb.size()), DIGEST_W'(0));
        $display("abort in squeeze: sq_req=%0b done=%0b", sq_req, done);

        // Reset while absorbing block 1 of a three-block job, then a fresh job.
        push_blocks(300);
        blk_ready = 1'b1;
        msg_len   = LEN_W'(300);
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_reset_in_block1", DIGEST_W'(blk_valid && !blk_last), DIGEST_W'(1));
        blk_ready = 1'b0;
        reset     = 1'b0;
        step();
        chk("midrst_blk_valid", DIGEST_W'(blk_valid), DIGEST_W'(0));
        chk("midrst_busy", DIGEST_W'(busy), DIGEST_W'(0));
        chk("midrst_done", DIGEST_W'(done), DIGEST_W'(0));
        chk("midrst_digest", digest, '0);
        exp_digest = '0;
        reset = 1'b1;
        sb.delete();
        step();
        $display("reset mid-absorb: blk_valid=%0b busy=%0b", blk_valid, busy);
        run_job(10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
